// File: rtl/bitvec_encoder_32_5.sv
// Sequential multi-hot to binary encoder: accepts an N-bit vector and emits the
// index of each set bit, lowest first, one per out_valid/out_ready handshake.
module bitvec_encoder_32_5 #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_vec_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_idx_o,
  output logic         out_last_o,
  output logic         busy_o,
  output logic         zero_drop_o,
  output logic         state_dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and outputs come only from flops.

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q;
  logic [N-1:0]   pend_q;
  logic [N-1:0]   pend_d;
  logic           zero_drop_q;
  logic [W-1:0]   low_idx;
  logic           is_last;
  logic           emit;

  // Clearing the lowest set bit is pend & (pend-1); empty result means last.
  always_comb begin
    pend_d  = pend_q & (pend_q - ONE);
    is_last = (pend_d == '0);
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = W'(i);
    end
  end

  assign emit        = (state_q == EMIT);
  assign in_ready_o  = ~emit;
  assign out_valid_o = emit;
  assign busy_o      = emit;
  assign out_idx_o   = emit ? low_idx : '0;
  assign out_last_o  = emit & is_last;
  assign zero_drop_o = zero_drop_q;
  assign state_dbg_o = state_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      zero_drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            if (in_vec_i == '0) begin
              zero_drop_q <= 1'b1;
            end else begin
              pend_q  <= in_vec_i;
              state_q <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready_i) begin
            pend_q <= pend_d;
            if (is_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitvec_encoder_32_5.sv
// Directed bench for bitvec_encoder_32_5: inputs change and outputs are
// sampled on the falling edge, so each sample reflects the preceding rising edge.
module tb_bitvec_encoder_32_5;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        zero_drop;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs_base;

  bitvec_encoder_32_5 #(.N(32), .W(5)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_vec_i    (in_vec),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .zero_drop_o (zero_drop),
    .state_dbg_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output handshakes that actually consume an index.
  always @(posedge clk) begin
    if (out_valid && out_ready && !flush && !reset) hs_cnt <= hs_cnt + 1;
  end

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_vec = 32'hFFFF_FFFF; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, zero_drop, out_last, out_idx} !== {4'b1000, 1'b0, 5'd0}) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got rdy=%b vld=%b busy=%b zd=%b last=%b idx=%0d, exp rdy=1 others 0",
                 c, in_ready, out_valid, busy, zero_drop, out_last, out_idx);
      end
      checks++;
      if (state_dbg !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got %b exp 0", c, state_dbg);
      end
    end
    reset = 1'b0; in_valid = 1'b0; in_vec = 32'h0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_no_accept: got vld=%b busy=%b rdy=%b exp 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp_idx [3];
    exp_idx[0] = 5'd0; exp_idx[1] = 5'd4; exp_idx[2] = 5'd31;
    out_ready = 1'b1;
    in_valid = 1'b1; in_vec = 32'h8000_0011;
    @(negedge clk);
    in_valid = 1'b0; in_vec = 32'h0000_DEAD;
    checks++;
    if ({in_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL basic_busy: got rdy=%b busy=%b exp 0 1", in_ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_last, out_idx} !== {1'b1, (i == 2), exp_idx[i]}) begin
        errors++;
        $display("FAIL basic_idx%0d: got vld=%b last=%b idx=%0d exp vld=1 last=%0d idx=%0d",
                 i, out_valid, out_last, out_idx, (i == 2), exp_idx[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({in_ready, out_valid, out_last, out_idx} !== {3'b100, 5'd0}) begin
      errors++;
      $display("FAIL basic_done: got rdy=%b vld=%b last=%b idx=%0d exp 1 0 0 0", in_ready, out_valid, out_last, out_idx);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    hs_base = hs_cnt;
    in_valid = 1'b1; in_vec = 32'h0000_0C00;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({out_valid, out_last, out_idx} !== {2'b10, 5'd10}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got vld=%b last=%b idx=%0d exp 1 0 10", c, out_valid, out_last, out_idx);
      end
      if (c == 3) out_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({out_valid, out_last, out_idx} !== {2'b11, 5'd11}) begin
      errors++;
      $display("FAIL bp_second: got vld=%b last=%b idx=%0d exp 1 1 11", out_valid, out_last, out_idx);
    end
    @(negedge clk);
    checks++;
    if ((hs_cnt - hs_base) !== 2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got %0d handshakes vld=%b exp 2 handshakes vld=0", hs_cnt - hs_base, out_valid);
    end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    in_valid = 1'b1; in_vec = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({zero_drop, out_valid, in_ready} !== 3'b101) begin
        errors++;
        $display("FAIL zero_pulse cycle %0d: got zd=%b vld=%b rdy=%b exp 1 0 1", c, zero_drop, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({zero_drop, out_valid, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL zero_end: got zd=%b vld=%b rdy=%b exp 0 0 1", zero_drop, out_valid, in_ready);
    end
    // A zero vector offered in a flush cycle is ignored entirely.
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({zero_drop, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL zero_flush: got zd=%b vld=%b exp 0 0", zero_drop, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    hs_base = hs_cnt;
    in_valid = 1'b1; in_vec = 32'h0000_00FF;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_idx} !== {1'b1, 5'(i)}) begin
        errors++;
        $display("FAIL flush_pre_idx%0d: got vld=%b idx=%0d exp 1 %0d", i, out_valid, out_idx, i);
      end
      if (i == 2) flush = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010 || (hs_cnt - hs_base) !== 2) begin
      errors++;
      $display("FAIL flush_abort: got vld=%b rdy=%b busy=%b hs=%0d exp 0 1 0 hs=2",
               out_valid, in_ready, busy, hs_cnt - hs_base);
    end
    in_valid = 1'b1; in_vec = 32'h0000_0100;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_last, out_idx} !== {2'b11, 5'd8}) begin
      errors++;
      $display("FAIL flush_next: got vld=%b last=%b idx=%0d exp 1 1 8", out_valid, out_last, out_idx);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_next_done: got vld=%b exp 0", out_valid);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b1;
    in_valid = 1'b1; in_vec = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if ({out_valid, out_last, out_idx} !== {1'b1, (i == 31), 5'(i)}) begin
        errors++;
        $display("FAIL full_idx%0d: got vld=%b last=%b idx=%0d exp 1 %0d %0d",
                 i, out_valid, out_last, out_idx, (i == 31), i);
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL full_done: got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({out_valid, out_idx} !== {1'b1, 5'(i)}) begin
        errors++;
        $display("FAIL full_rst_idx%0d: got vld=%b idx=%0d exp 1 %0d", i, out_valid, out_idx, i);
      end
      if (i == 15) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready, out_idx} !== {3'b001, 5'd0}) begin
      errors++;
      $display("FAIL full_rst_abort: got vld=%b busy=%b rdy=%b idx=%0d exp 0 0 1 0", out_valid, busy, in_ready, out_idx);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_idx} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL full_rst_quiet: got vld=%b idx=%0d exp 0 0", out_valid, out_idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_flush();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
